debouncer_bank: RTL

- Multi-channel switch/button conditioner for board inputs such as game controls and DIP switches.
- Per channel:
  - 2-flop synchroniser
  - stability counter
  - debounced level
  - single-cycle press/release strobes
  - optional held-key auto-repeat strobe
- Sits between raw pads and game/control FSMs, which consume strobes directly instead of doing their own edge detection.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debouncer_bank_if.sv | 26 ++
 rtl/debounce_channel.sv | 87 ++++++++
 rtl/debouncer_bank.sv | 45 ++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and timing helpers for the debouncer bank
package debounce_pkg;

    localparam int SYNC_STAGES = 2;

    function automatic int settle_cycles(input int counter_size);
        return (1 << counter_size) + 2;
    endfunction

    function automatic int repeat_cycles(input int size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// rtl/debouncer_bank_if.sv - raw button inputs and conditioned level/strobe outputs
interface debouncer_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] released;
    logic [CHANNELS-1:0] repeat_pulse;

    modport master (
        output button,
        input  level,
        input  pressed,
        input  released,
        input  repeat_pulse
    );

    modport slave (
        input  button,
        output level,
        output pressed,
        output released,
        output repeat_pulse
    );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, stability counter, strobes and auto-repeat
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int COUNTER_SIZE      = 8,
    parameter bit REPEAT_EN         = 1'b0,
    parameter int REPEAT_DELAY_SIZE = 20,
    parameter int REPEAT_RATE_SIZE  = 18
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic level,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);
    localparam int CW = COUNTER_SIZE + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sync_new;
    logic                   sync_old;
    logic                   stable;
    logic                   update;

    assign sync_new = sync[SYNC_STAGES-2];
    assign sync_old = sync[SYNC_STAGES-1];
    assign stable   = (sync_new == sync_old);
    assign update   = cnt[CW-1] && stable && (level != sync_old);

    // Counter saturates at its MSB so a long-stable input never re-arms by wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= '0;
            cnt      <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], button};
            if (!stable)
                cnt <= '0;
            else if (!cnt[CW-1])
                cnt <= cnt + CW'(1);
            if (update)
                level <= sync_old;
            pressed  <= update &  sync_old;
            released <= update & ~sync_old;
        end
    end

    if (REPEAT_EN) begin : g_repeat
        localparam int RW = (REPEAT_DELAY_SIZE > REPEAT_RATE_SIZE) ? REPEAT_DELAY_SIZE : REPEAT_RATE_SIZE;
        localparam logic [RW-1:0] FIRST_LAST = RW'(repeat_cycles(REPEAT_DELAY_SIZE) - 1);
        localparam logic [RW-1:0] RATE_LAST  = RW'(repeat_cycles(REPEAT_RATE_SIZE) - 1);

        logic [RW-1:0] rcnt;
        logic          first;
        logic          hit;

        assign hit = (rcnt == (first ? FIRST_LAST : RATE_LAST));

        // While level is high, update can only mean a release, which must swallow a coincident repeat.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rcnt         <= '0;
                first        <= 1'b1;
                repeat_pulse <= 1'b0;
            end else if (!level) begin
                rcnt         <= '0;
                first        <= 1'b1;
                repeat_pulse <= 1'b0;
            end else if (hit) begin
                rcnt         <= '0;
                first        <= 1'b0;
                repeat_pulse <= ~update;
            end else begin
                rcnt         <= rcnt + RW'(1);
                repeat_pulse <= 1'b0;
            end
        end
    end else begin : g_no_repeat
        assign repeat_pulse = 1'b0;
    end

endmodule

// File: rtl/debouncer_bank.sv
// rtl/debouncer_bank.sv - bank of independent debounced channels with optional input inversion
module debouncer_bank #(
    parameter int                  CHANNELS          = 4,
    parameter int                  COUNTER_SIZE      = 8,
    parameter logic [CHANNELS-1:0] INVERT            = {CHANNELS{1'b0}},
    parameter bit                  REPEAT_EN         = 1'b0,
    parameter int                  REPEAT_DELAY_SIZE = 20,
    parameter int                  REPEAT_RATE_SIZE  = 18
) (
    input  logic             clock,
    input  logic             reset_n,
    debouncer_bank_if.slave  bus
);
    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] pressed_w;
    logic [CHANNELS-1:0] released_w;
    logic [CHANNELS-1:0] repeat_w;
    logic [CHANNELS-1:0] active;

    // Active-low pads are flipped before the synchroniser so every channel reads 1 = pressed.
    assign active = bus.button ^ INVERT;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .COUNTER_SIZE      (COUNTER_SIZE),
            .REPEAT_EN         (REPEAT_EN),
            .REPEAT_DELAY_SIZE (REPEAT_DELAY_SIZE),
            .REPEAT_RATE_SIZE  (REPEAT_RATE_SIZE)
        ) u_channel (
            .clock        (clock),
            .reset_n      (reset_n),
            .button       (active[i]),
            .level        (level_w[i]),
            .pressed      (pressed_w[i]),
            .released     (released_w[i]),
            .repeat_pulse (repeat_w[i])
        );
    end

    assign bus.level        = level_w;
    assign bus.pressed      = pressed_w;
    assign bus.released     = released_w;
    assign bus.repeat_pulse = repeat_w;

endmodule
